tank_motion_ctrl: RTL

Parametrised joystick-driven sprite controller for the VGA pipeline. It sits between the background/timing stage and the next overlay stage, and passes all timing signals through with one register stage. It moves a rectangular tank sprite from a 10-bit two-axis joystick, using a speed-ramp state machine, a per-axis clamp to a configurable play field, and a heading output. It overlays the sprite onto `rgb_in` when game mode is selected.

---
 rtl/tank_motion_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tank_motion_ctrl.sv
// Joystick-driven tank sprite: speed-ramp FSM, clamped per-axis motion, heading and overlay.
// Build option: define TANK_OUTLINE_EN to draw the sprite's outer 1-pixel border in white.
module tank_motion_ctrl #(
    parameter int          X0         = 200,
    parameter int          Y0         = 200,
    parameter int          SPRITE_W   = 20,
    parameter int          SPRITE_H   = 20,
    parameter int          DEAD_LO    = 400,
    parameter int          DEAD_HI    = 600,
    parameter int          TICK_DIV   = 1000000,
    parameter int          MAX_SPEED  = 4,
    parameter int          X_MIN      = 3,
    parameter int          X_MAX      = 1004,
    parameter int          Y_MIN      = 3,
    parameter int          Y_MAX      = 744,
    parameter logic [11:0] SPRITE_RGB = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        select_mode,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hblnk,
    input  logic        vblnk,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb_in,
    input  logic [9:0]  joy_x,
    input  logic [9:0]  joy_y,
    output logic        select_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [11:0] rgb_out,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [2:0]  heading,
    output logic [3:0]  speed
);

    localparam int                     CNT_W       = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]       CNT_LAST    = CNT_W'(TICK_DIV - 1);
    localparam logic [9:0]             DEAD_LO_V   = 10'(DEAD_LO);
    localparam logic [9:0]             DEAD_HI_V   = 10'(DEAD_HI);
    localparam logic [3:0]             MAX_SPEED_V = 4'(MAX_SPEED);
    localparam logic signed [12:0]     X_MIN_S     = 13'(X_MIN);
    localparam logic signed [12:0]     X_MAX_S     = 13'(X_MAX);
    localparam logic signed [12:0]     Y_MIN_S     = 13'(Y_MIN);
    localparam logic signed [12:0]     Y_MAX_S     = 13'(Y_MAX);
    localparam logic [11:0]            X0_V        = 12'(X0);
    localparam logic [11:0]            Y0_V        = 12'(Y0);
    localparam logic [12:0]            W_V         = 13'(SPRITE_W);
    localparam logic [12:0]            H_V         = 13'(SPRITE_H);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RAMP   = 2'd1;
    localparam logic [1:0] ST_CRUISE = 2'd2;

    typedef struct packed {
        logic        select;
        logic [10:0] hcount;
        logic [9:0]  vcount;
        logic        hblnk;
        logic        vblnk;
        logic        hsync;
        logic        vsync;
        logic [11:0] rgb;
    } vid_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic [11:0]      xpos_q, xpos_d;
    logic [11:0]      ypos_q, ypos_d;
    logic [3:0]       speed_q, speed_d;
    logic [2:0]       heading_q, heading_d;
    vid_t             vid_q, vid_d;

    logic             tick;
    logic             dx_pos, dx_neg, dy_pos, dy_neg;
    logic             moving, turn;
    logic [2:0]       dir_heading;
    logic [12:0]      h_ext, v_ext, x_ext, y_ext, x_end, y_end;
    logic             in_sprite;

    // Moves one axis by +/-spd in 13-bit signed space, then saturates into [lo, hi].
    function automatic logic [11:0] step_clamp(
        input logic [11:0]        pos,
        input logic               inc,
        input logic               dec,
        input logic [3:0]         spd,
        input logic signed [12:0] lo,
        input logic signed [12:0] hi
    );
        logic signed [12:0] sum;
        sum = $signed({1'b0, pos});
        if (inc)      sum = sum + $signed({9'd0, spd});
        else if (dec) sum = sum - $signed({9'd0, spd});
        if (sum < lo)      sum = lo;
        else if (sum > hi) sum = hi;
        return sum[11:0];
    endfunction

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        dx_pos = (joy_x < DEAD_LO_V);
        dx_neg = (joy_x > DEAD_HI_V);
        dy_pos = (joy_y < DEAD_LO_V);
        dy_neg = (joy_y > DEAD_HI_V);
        moving = dx_pos | dx_neg | dy_pos | dy_neg;
        // Deadzone on both axes leaves the last heading in place.
        case ({dx_pos, dx_neg, dy_pos, dy_neg})
            4'b1000: dir_heading = 3'd0;
            4'b1010: dir_heading = 3'd1;
            4'b0010: dir_heading = 3'd2;
            4'b0110: dir_heading = 3'd3;
            4'b0100: dir_heading = 3'd4;
            4'b0101: dir_heading = 3'd5;
            4'b0001: dir_heading = 3'd6;
            4'b1001: dir_heading = 3'd7;
            default: dir_heading = heading_q;
        endcase
        turn = (dir_heading != heading_q);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        state_d   = state_q;
        speed_d   = speed_q;
        heading_d = heading_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        if (!select_mode) begin
            state_d = ST_IDLE;
            speed_d = 4'd0;
            xpos_d  = X0_V;
            ypos_d  = Y0_V;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (moving) begin
                        state_d   = ST_RAMP;
                        speed_d   = 4'd1;
                        heading_d = dir_heading;
                    end
                end
                ST_RAMP, ST_CRUISE: begin
                    if (!moving) begin
                        state_d = ST_IDLE;
                        speed_d = 4'd0;
                    end else if (turn) begin
                        state_d   = ST_RAMP;
                        speed_d   = 4'd1;
                        heading_d = dir_heading;
                    end else if (speed_q < MAX_SPEED_V) begin
                        speed_d = speed_q + 4'd1;
                        if (speed_d == MAX_SPEED_V) state_d = ST_CRUISE;
                    end else begin
                        state_d = ST_CRUISE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    speed_d = 4'd0;
                end
            endcase
            xpos_d = step_clamp(xpos_q, dx_pos, dx_neg, speed_d, X_MIN_S, X_MAX_S);
            ypos_d = step_clamp(ypos_q, dy_pos, dy_neg, speed_d, Y_MIN_S, Y_MAX_S);
        end
    end

    always_comb begin
        h_ext     = {2'b00, hcount};
        v_ext     = {3'b000, vcount};
        x_ext     = {1'b0, xpos_q};
        y_ext     = {1'b0, ypos_q};
        x_end     = x_ext + W_V;
        y_end     = y_ext + H_V;
        in_sprite = (h_ext >= x_ext) && (h_ext < x_end) && (v_ext >= y_ext) && (v_ext < y_end);

        vid_d.select = select_mode;
        vid_d.hcount = hcount;
        vid_d.vcount = vcount;
        vid_d.hblnk  = hblnk;
        vid_d.vblnk  = vblnk;
        vid_d.hsync  = hsync;
        vid_d.vsync  = vsync;
        vid_d.rgb    = rgb_in;
        if (select_mode && in_sprite) begin
`ifdef TANK_OUTLINE_EN
            if ((h_ext == x_ext) || (h_ext == x_end - 13'd1) ||
                (v_ext == y_ext) || (v_ext == y_end - 13'd1))
                vid_d.rgb = 12'hFFF;
            else
                vid_d.rgb = SPRITE_RGB;
`else
            vid_d.rgb = SPRITE_RGB;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            speed_q   <= 4'd0;
            heading_q <= 3'd0;
            xpos_q    <= X0_V;
            ypos_q    <= Y0_V;
            vid_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            speed_q   <= speed_d;
            heading_q <= heading_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            vid_q     <= vid_d;
        end
    end

    assign select_out = vid_q.select;
    assign hcount_out = vid_q.hcount;
    assign vcount_out = vid_q.vcount;
    assign hblnk_out  = vid_q.hblnk;
    assign vblnk_out  = vid_q.vblnk;
    assign hsync_out  = vid_q.hsync;
    assign vsync_out  = vid_q.vsync;
    assign rgb_out    = vid_q.rgb;
    assign xpos       = xpos_q;
    assign ypos       = ypos_q;
    assign speed      = speed_q;
    assign heading    = heading_q;

endmodule
